// File: rtl/fir_pkg.sv
// Shared constants and FSM encoding for the FIR coefficient loading path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fir_pkg;

    localparam int ORD   = 256;
    localparam int C     = 16;
    localparam int NCOEF = (ORD + 1) / 2;
    localparam int AW    = $clog2(NCOEF);
    localparam int BPC   = C / 8;
    localparam int BCW   = (BPC > 1) ? $clog2(BPC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

endpackage

// File: rtl/fir_coeff_loader_if.sv
// Byte stream carrying coefficient bytes (MSB byte first) into the loader.
// Latency: wires only.
// Backpressure: a byte moves on a cycle with s_valid && s_ready.
interface fir_coeff_loader_if;

    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);

endinterface

// File: rtl/fir_coeff_loader.sv
// Packs a byte stream MSB-first into C-bit coefficients and writes them to the FIR (optional trailer checksum: COEF_LOADER_CHK_EN).
// Latency: c_WE pulses the cycle after the last byte of a coefficient; BPC+1 cycles per coefficient at best.
// Backpressure: s_ready only in RECV/CHECK; drops for the one-cycle WRITE; s_valid low simply stalls.
module fir_coeff_loader
    import fir_pkg::*;
(
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 start,
    input  logic                 abort,
    fir_coeff_loader_if.slave    s,
    output logic                 c_WE,
    output logic [C-1:0]         c_in,
    output logic [AW-1:0]        c_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    state_t          state_q, state_d;
    logic [C-1:0]    word_q, word_d;
    logic [BCW-1:0]  bcnt_q, bcnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [C-1:0]    c_in_q, c_in_d;
    logic            c_we_q, c_we_d;
    logic            s_ready_q, s_ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
`ifdef COEF_LOADER_CHK_EN
    logic [7:0]      chk_q, chk_d;
`endif

    logic byte_acc;
    logic last_byte;
    logic last_addr;

    assign byte_acc  = s.s_valid && s_ready_q;
    assign last_byte = (bcnt_q == BCW'(BPC - 1));
    assign last_addr = (addr_q == AW'(NCOEF - 1));

    // FSM state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state: abort beats any byte; start is only looked at in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RECV;
            end
            ST_RECV: begin
                if (abort)                       state_d = ST_IDLE;
                else if (byte_acc && last_byte)  state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (abort)          state_d = ST_IDLE;
`ifdef COEF_LOADER_CHK_EN
                else if (last_addr) state_d = ST_CHECK;
`else
                else if (last_addr) state_d = ST_IDLE;
`endif
                else                state_d = ST_RECV;
            end
            ST_CHECK: begin
                if (abort || byte_acc) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next-values; strobes are derived from the state being entered
    always_comb begin
        word_d    = word_q;
        bcnt_d    = bcnt_q;
        addr_d    = addr_q;
        c_in_d    = c_in_q;
        done_d    = done_q;
        err_d     = err_q;
`ifdef COEF_LOADER_CHK_EN
        chk_d     = chk_q;
`endif
        c_we_d    = (state_d == ST_WRITE);
        s_ready_d = (state_d == ST_RECV) || (state_d == ST_CHECK);
        busy_d    = (state_d != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    addr_d = '0;
                    bcnt_d = '0;
`ifdef COEF_LOADER_CHK_EN
                    chk_d  = '0;
`endif
                end
            end
            ST_RECV: begin
                if (abort) begin
                    err_d = 1'b1;
                end else if (byte_acc) begin
                    word_d = {word_q[C-9:0], s.s_data};
                    bcnt_d = bcnt_q + BCW'(1);
`ifdef COEF_LOADER_CHK_EN
                    chk_d  = chk_q ^ s.s_data;
`endif
                end
            end
            ST_WRITE: begin
                if (abort) begin
                    err_d = 1'b1;
                end else if (last_addr) begin
`ifndef COEF_LOADER_CHK_EN
                    done_d = 1'b1;
`endif
                end else begin
                    addr_d = addr_q + AW'(1);
                    bcnt_d = '0;
                end
            end
            ST_CHECK: begin
                if (abort) begin
                    err_d = 1'b1;
                end else if (byte_acc) begin
`ifdef COEF_LOADER_CHK_EN
                    if (s.s_data == chk_q) done_d = 1'b1;
                    else                   err_d  = 1'b1;
`endif
                end
            end
            default: ;
        endcase

        // The completed word is presented together with the write strobe
        if (state_d == ST_WRITE) c_in_d = word_d;
    end

    // Datapath and registered outputs; reset clears everything including the strobe
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            word_q    <= '0;
            bcnt_q    <= '0;
            addr_q    <= '0;
            c_in_q    <= '0;
            c_we_q    <= 1'b0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            word_q    <= word_d;
            bcnt_q    <= bcnt_d;
            addr_q    <= addr_d;
            c_in_q    <= c_in_d;
            c_we_q    <= c_we_d;
            s_ready_q <= s_ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

`ifdef COEF_LOADER_CHK_EN
    // Running XOR of payload bytes, compared against the trailer
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) chk_q <= '0;
        else       chk_q <= chk_d;
    end
`endif

    assign s.s_ready = s_ready_q;
    assign c_WE      = c_we_q;
    assign c_in      = c_in_q;
    assign c_addr    = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomized bench for fir_coeff_loader against a byte-list model of the coefficient writes.
// Latency: inputs change on negedge, outputs sampled on negedge.
// Backpressure: bytes are held until s_ready is seen, with a bounded wait.
module tb_fir_coeff_loader;
    import fir_pkg::*;

    logic            clk;
    logic            nrst;
    logic            start;
    logic            abort;
    logic            c_WE;
    logic [C-1:0]    c_in;
    logic [AW-1:0]   c_addr;
    logic            busy;
    logic            done;
    logic            err;

    fir_coeff_loader_if ifc ();

    fir_coeff_loader dut (
        .clk    (clk),
        .nrst   (nrst),
        .start  (start),
        .abort  (abort),
        .s      (ifc),
        .c_WE   (c_WE),
        .c_in   (c_in),
        .c_addr (c_addr),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit stuck    = 0;

    logic [7:0]       pay [NCOEF*BPC];
    logic [AW+C-1:0]  wr_q [$];
    int               dbl_cnt = 0;
    bit               we_prev = 0;
`ifdef COEF_LOADER_CHK_EN
    bit               corrupt_trl = 0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: records every strobe and flags back-to-back strobes
    always @(negedge clk) begin
        if (c_WE) begin
            wr_q.push_back({c_addr, c_in});
            if (we_prev) dbl_cnt++;
        end
        we_prev = c_WE;
    end

    // Present one byte and hold it until the loader takes it
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        if (stuck) return;
        ifc.s_data  = b;
        ifc.s_valid = 1'b1;
        while (!ifc.s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            $display("FAIL byte_accept: s_ready=%0b after %0d cycles, required 1", ifc.s_ready, n);
            stuck = 1;
            ifc.s_valid = 1'b0;
            return;
        end
        @(negedge clk);
        ifc.s_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NCOEF*BPC; i++) pay[i] = 8'($urandom);
    endtask

    // Full load of pay[] plus checks of the resulting writes and status
    task automatic run_session(input bit gaps, input bit start_mid, input string name);
        logic [7:0]   x;
        logic [C-1:0] e;
        int           n, nbad, badi;
        bit           exp_done, exp_err;
        exp_done = 1'b1;
        exp_err  = 1'b0;
        x = 8'h00;
        pulse_start();
        wr_q.delete();
        dbl_cnt = 0;
        n_checks++;
        if ({busy, err, done} !== 3'b100) begin
            $display("FAIL %s_start: busy/err/done=%b required 100", name, {busy, err, done});
        end else n_pass++;
        for (int i = 0; i < NCOEF*BPC; i++) begin
            if (gaps) repeat ($urandom_range(0, 1)) @(negedge clk);
            if (start_mid && i == 10) start = 1'b1;
            send_byte(pay[i]);
            start = 1'b0;
            x = x ^ pay[i];
        end
`ifdef COEF_LOADER_CHK_EN
        send_byte(corrupt_trl ? (x ^ 8'h01) : x);
        exp_done = !corrupt_trl;
        exp_err  = corrupt_trl;
`endif
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s_finish: busy=%b required 0", name, busy);
        else n_pass++;
        n_checks++;
        if (wr_q.size() != NCOEF) $display("FAIL %s_count: writes=%0d required %0d", name, wr_q.size(), NCOEF);
        else n_pass++;
        nbad = 0;
        badi = -1;
        for (int i = 0; i < NCOEF && i < wr_q.size(); i++) begin
            e = '0;
            for (int k = 0; k < BPC; k++) e = {e[C-9:0], pay[i*BPC+k]};
            if (wr_q[i] !== {AW'(i), e}) begin
                nbad++;
                if (badi < 0) badi = i;
            end
        end
        n_checks++;
        if (nbad != 0) begin
            e = '0;
            for (int k = 0; k < BPC; k++) e = {e[C-9:0], pay[badi*BPC+k]};
            $display("FAIL %s_data: %0d bad writes, first #%0d addr/data=%h required %h",
                     name, nbad, badi, wr_q[badi], {AW'(badi), e});
        end else n_pass++;
        n_checks++;
        if (dbl_cnt != 0) $display("FAIL %s_we_pulse: back-to-back c_WE seen %0d times, required 0", name, dbl_cnt);
        else n_pass++;
        n_checks++;
        if ({done, err} !== {exp_done, exp_err})
            $display("FAIL %s_status: done/err=%b required %b", name, {done, err}, {exp_done, exp_err});
        else n_pass++;
        n_checks++;
        if (c_addr !== AW'(NCOEF-1)) $display("FAIL %s_addr_hold: c_addr=%0d required %0d", name, c_addr, NCOEF-1);
        else n_pass++;
    endtask

    task automatic check_reset_values(input string name);
        n_checks++;
        if ({ifc.s_ready, c_WE, busy, done, err} !== 5'b0)
            $display("FAIL %s_flags: s_ready/c_WE/busy/done/err=%b required 00000",
                     name, {ifc.s_ready, c_WE, busy, done, err});
        else n_pass++;
        n_checks++;
        if (c_in !== '0) $display("FAIL %s_c_in: c_in=%h required 0", name, c_in);
        else n_pass++;
        n_checks++;
        if (c_addr !== '0) $display("FAIL %s_c_addr: c_addr=%0d required 0", name, c_addr);
        else n_pass++;
    endtask

    task automatic test_reset();
        nrst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        ifc.s_valid = 1'b0;
        ifc.s_data = 8'h00;
        #1 nrst = 1'b0;
        #1 check_reset_values("reset");
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check_reset_values("reset_release");
    endtask

    task automatic test_ramp();
        for (int i = 0; i < NCOEF; i++) begin
            pay[2*i]   = 8'((i + 1) >> 8);
            pay[2*i+1] = 8'(i + 1);
        end
        run_session(1'b0, 1'b0, "ramp");
    endtask

    task automatic test_gaps();
        for (int i = 0; i < NCOEF*BPC; i++) pay[i] = 8'hA5;
        run_session(1'b1, 1'b0, "gaps_a5");
        fill_random();
        run_session(1'b1, 1'b0, "gaps_rand");
    endtask

    task automatic test_abort();
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
        pulse_start();
        wr_q.delete();
        for (int i = 0; i < 3; i++) send_byte(b[i]);
        ifc.s_data  = b[3];
        ifc.s_valid = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        ifc.s_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({err, busy, done, ifc.s_ready} !== 4'b1000)
            $display("FAIL abort_status: err/busy/done/s_ready=%b required 1000", {err, busy, done, ifc.s_ready});
        else n_pass++;
        n_checks++;
        if (wr_q.size() != 1) $display("FAIL abort_count: writes=%0d required 1", wr_q.size());
        else n_pass++;
        n_checks++;
        if (wr_q.size() >= 1 && wr_q[0] !== {AW'(0), b[0], b[1]})
            $display("FAIL abort_data: addr/data=%h required %h", wr_q[0], {AW'(0), b[0], b[1]});
        else if (wr_q.size() >= 1) n_pass++;
        fill_random();
        run_session(1'b1, 1'b0, "after_abort");
    endtask

    task automatic test_reset_mid();
        fill_random();
        pulse_start();
        for (int i = 0; i < 40*BPC; i++) send_byte(pay[i]);
        n_checks++;
        if ({c_WE, c_addr} !== {1'b1, AW'(39)})
            $display("FAIL midreset_pre: c_WE/c_addr=%b/%0d required 1/39", c_WE, c_addr);
        else n_pass++;
        nrst = 1'b0;
        #1 check_reset_values("midreset");
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        fill_random();
        run_session(1'b0, 1'b0, "after_midreset");
    endtask

`ifdef COEF_LOADER_CHK_EN
    task automatic test_chk();
        fill_random();
        corrupt_trl = 1'b0;
        run_session(1'b1, 1'b0, "chk_good");
        fill_random();
        corrupt_trl = 1'b1;
        run_session(1'b0, 1'b0, "chk_bad");
        corrupt_trl = 1'b0;
    endtask
`endif

    task automatic test_idle_ignore();
        int nrdy;
        fill_random();
        run_session(1'b0, 1'b1, "start_mid");
        wr_q.delete();
        nrdy = 0;
        ifc.s_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ifc.s_data = 8'($urandom);
            @(negedge clk);
            if (ifc.s_ready !== 1'b0) nrdy++;
        end
        ifc.s_valid = 1'b0;
        n_checks++;
        if (nrdy != 0) $display("FAIL idle_s_ready: s_ready high %0d cycles, required 0", nrdy);
        else n_pass++;
        n_checks++;
        if (wr_q.size() != 0) $display("FAIL idle_no_write: writes=%0d required 0", wr_q.size());
        else n_pass++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done, err} !== 3'b010)
            $display("FAIL idle_abort: busy/done/err=%b required 010", {busy, done, err});
        else n_pass++;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        n_checks++;
        if ({busy, done, err, ifc.s_ready} !== 4'b1001)
            $display("FAIL start_abort_idle: busy/done/err/s_ready=%b required 1001", {busy, done, err, ifc.s_ready});
        else n_pass++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if ({busy, err} !== 2'b01) $display("FAIL abort_recv: busy/err=%b required 01", {busy, err});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_gaps();
        test_abort();
        test_reset_mid();
`ifdef COEF_LOADER_CHK_EN
        test_chk();
`endif
        test_idle_ignore();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
